// File: rtl/fp_mul_seq.sv
// Iterative IEEE-754 multiplier: one radix-4 Booth digit per cycle, then one normalise/round cycle.
// Special operands take a single-cycle bypass straight to the result stage.
module fp_mul_seq #(
  parameter int EXP_W = 8,
  parameter int FRC_W = 23
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [EXP_W+FRC_W:0]     fp_X,
  input  logic [EXP_W+FRC_W:0]     fp_Y,
  input  logic [2:0]               r_mode,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [EXP_W+FRC_W:0]     fp_Z,
  output logic                     ovrf,
  output logic                     udrf,
  output logic [2*(FRC_W+1)-1:0]   dbg_prod
);

  localparam int W     = 1 + EXP_W + FRC_W;
  localparam int M     = FRC_W + 1;
  localparam int NDIG  = (M + 2) / 2;
  localparam int ACC_W = 2 * M + 2;
  localparam int CNT_W = $clog2(NDIG);
  localparam int E_W   = EXP_W + 2;
  localparam int BIAS  = 2 ** (EXP_W - 1) - 1;

  localparam logic [CNT_W-1:0]      LAST_DIG = CNT_W'(NDIG - 1);
  localparam logic signed [E_W-1:0] BIAS_E   = E_W'(BIAS);
  localparam logic signed [E_W-1:0] EMAX_E   = E_W'(2 ** EXP_W - 1);
  localparam logic signed [E_W-1:0] E_ONE    = E_W'(1);
  localparam logic [W-1:0]          QNAN     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRC_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MUL, ROUND, DONE} state_t;
  typedef enum logic [2:0] {
    RM_RNE = 3'b000,
    RM_RTZ = 3'b001,
    RM_RDN = 3'b010,
    RM_RUP = 3'b011,
    RM_RMM = 3'b100
  } rmode_t;

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic [ACC_W-1:0]        acc;
  logic [ACC_W-1:0]        mc;
  logic [M+2:0]            y_sh;
  logic                    sgn;
  logic signed [E_W-1:0]   e_sum;
  logic [2:0]              rm;

  // Operand decode
  logic                    x_s, y_s;
  logic [EXP_W-1:0]        x_exp, y_exp;
  logic [FRC_W-1:0]        x_frc, y_frc;
  logic                    x_nan, y_nan, x_inf, y_inf, x_zero, y_zero;
  logic                    spc_hit;
  logic [W-1:0]            spc_z;

  assign x_s    = fp_X[W-1];
  assign y_s    = fp_Y[W-1];
  assign x_exp  = fp_X[W-2:FRC_W];
  assign y_exp  = fp_Y[W-2:FRC_W];
  assign x_frc  = fp_X[FRC_W-1:0];
  assign y_frc  = fp_Y[FRC_W-1:0];
  assign x_nan  = (&x_exp) && (|x_frc);
  assign y_nan  = (&y_exp) && (|y_frc);
  assign x_inf  = (&x_exp) && !(|x_frc);
  assign y_inf  = (&y_exp) && !(|y_frc);
  assign x_zero = ~|x_exp;
  assign y_zero = ~|y_exp;

  // Subnormals are flushed, so an all-zero exponent counts as zero here.
  always_comb begin
    spc_hit = 1'b1;
    spc_z   = '0;
    if (x_nan || y_nan || (x_zero && y_inf) || (x_inf && y_zero))
      spc_z = QNAN;
    else if (x_inf || y_inf)
      spc_z = {x_s ^ y_s, {EXP_W{1'b1}}, {FRC_W{1'b0}}};
    else if (x_zero || y_zero)
      spc_z = {x_s ^ y_s, {(W-1){1'b0}}};
    else
      spc_hit = 1'b0;
  end

  // Booth digit selection: y_sh[2:0] is {Y[2i+1], Y[2i], Y[2i-1]}; mc holds X * 4**i.
  logic [ACC_W-1:0] mc2;
  logic [ACC_W-1:0] pp;

  always_comb begin
    mc2 = mc << 1;
    case (y_sh[2:0])
      3'b001, 3'b010: pp = mc;
      3'b011:         pp = mc2;
      3'b100:         pp = -mc2;
      3'b101, 3'b110: pp = -mc;
      default:        pp = '0;
    endcase
  end

  // Normalise and round
  logic [2*M-1:0]          prod;
  logic                    acc_unused;
  logic                    norm_hi;
  logic [M-1:0]            sig;
  logic                    grd, stk, inc;
  logic [M:0]              sig_r;
  logic signed [E_W-1:0]   e_n, e_r;
  logic [FRC_W-1:0]        frc_r;
  logic [W-1:0]            rnd_z;
  logic                    rnd_ovf, rnd_udf;
  logic [W-1:0]            inf_z, max_z;

  assign prod       = acc[2*M-1:0];
  assign acc_unused = |acc[ACC_W-1:2*M];
  assign inf_z      = {sgn, {EXP_W{1'b1}}, {FRC_W{1'b0}}};
  assign max_z      = {sgn, {(EXP_W-1){1'b1}}, 1'b0, {FRC_W{1'b1}}};

  always_comb begin
    norm_hi = prod[2*M-1];
    if (norm_hi) begin
      sig = prod[2*M-1:M];
      grd = prod[M-1];
      stk = |prod[M-2:0];
    end else begin
      sig = prod[2*M-2:M-1];
      grd = prod[M-2];
      stk = |prod[M-3:0];
    end
    e_n = e_sum + {{(E_W-1){1'b0}}, norm_hi};

    case (rm)
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = (grd | stk) & sgn;
      RM_RUP:  inc = (grd | stk) & ~sgn;
      RM_RMM:  inc = grd;
      default: inc = grd & (stk | sig[0]);
    endcase

    sig_r = {1'b0, sig} + {{M{1'b0}}, inc};
    if (sig_r[M]) begin
      e_r   = e_n + E_ONE;
      frc_r = '0;
    end else begin
      e_r   = e_n;
      frc_r = sig_r[M-2:0];
    end

    rnd_z   = {sgn, e_r[EXP_W-1:0], frc_r};
    rnd_ovf = 1'b0;
    rnd_udf = 1'b0;
    if (e_n[E_W-1] || (e_n == '0)) begin
      rnd_z   = {sgn, {(W-1){1'b0}}};
      rnd_udf = 1'b1;
    end else if (e_r >= EMAX_E) begin
      rnd_ovf = 1'b1;
      case (rm)
        RM_RTZ:  rnd_z = max_z;
        RM_RDN:  rnd_z = sgn ? inf_z : max_z;
        RM_RUP:  rnd_z = sgn ? max_z : inf_z;
        default: rnd_z = inf_z;
      endcase
    end
  end

  // Result registers are loaded one state ahead of out_valid, which DONE raises on its first cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      fp_Z      <= '0;
      ovrf      <= 1'b0;
      udrf      <= 1'b0;
      dbg_prod  <= '0;
      cnt       <= '0;
      acc       <= '0;
      mc        <= '0;
      y_sh      <= '0;
      sgn       <= 1'b0;
      e_sum     <= '0;
      rm        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            in_ready <= 1'b0;
            rm       <= r_mode;
            sgn      <= x_s ^ y_s;
            e_sum    <= $signed({2'b00, x_exp}) + $signed({2'b00, y_exp}) - BIAS_E;
            if (spc_hit) begin
              fp_Z     <= spc_z;
              ovrf     <= 1'b0;
              udrf     <= 1'b0;
              dbg_prod <= '0;
              state    <= DONE;
            end else begin
              acc   <= '0;
              mc    <= ACC_W'({1'b1, x_frc});
              y_sh  <= {2'b00, 1'b1, y_frc, 1'b0};
              cnt   <= '0;
              state <= MUL;
            end
          end
        end
        MUL: begin
          acc  <= acc + pp;
          mc   <= mc << 2;
          y_sh <= y_sh >> 2;
          cnt  <= cnt + 1'b1;
          if (cnt == LAST_DIG)
            state <= ROUND;
        end
        ROUND: begin
          fp_Z     <= rnd_z;
          ovrf     <= rnd_ovf;
          udrf     <= rnd_udf;
          dbg_prod <= prod;
          state    <= DONE;
        end
        DONE: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_mul_seq.sv
// Directed-vector bench for fp_mul_seq: results, flags, latency, output hold and mid-operation reset.
module tb_fp_mul_seq;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] fp_X;
  logic [31:0] fp_Y;
  logic [2:0]  r_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] fp_Z;
  logic        ovrf;
  logic        udrf;
  logic [47:0] dbg_prod;

  int checks = 0;
  int errors = 0;

  logic [31:0] got_z;
  logic        got_ov, got_ud, got_rdy;
  logic [47:0] got_prod;
  int          got_lat;

  fp_mul_seq #(.EXP_W(8), .FRC_W(23)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .fp_X      (fp_X),
    .fp_Y      (fp_Y),
    .r_mode    (r_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .fp_Z      (fp_Z),
    .ovrf      (ovrf),
    .udrf      (udrf),
    .dbg_prod  (dbg_prod)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Accept one operation, keep in_valid high with junk operands while busy, wait for out_valid.
  task automatic issue(input logic [31:0] x, input logic [31:0] y, input logic [2:0] rm);
    int n;
    @(negedge clk);
    fp_X = x; fp_Y = y; r_mode = rm; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    fp_X = 32'hDEADBEEF; fp_Y = 32'h12345678; r_mode = 3'd1;
    got_lat = 0;
    do begin
      @(posedge clk); #1;
      got_lat++;
    end while (!out_valid && got_lat < 100);
    in_valid = 1'b0;
    got_z = fp_Z; got_ov = ovrf; got_ud = udrf; got_prod = dbg_prod; got_rdy = in_ready;
  endtask

  task automatic release_out(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, ".in_ready_after"}, in_ready, 1'b1);
    check({tag, ".out_valid_after"}, out_valid, 1'b0);
  endtask

  task automatic run(input string tag, input logic [31:0] x, input logic [31:0] y,
                     input logic [2:0] rm, input logic [31:0] ez, input logic eov,
                     input logic eud, input int elat);
    issue(x, y, rm);
    check({tag, ".lat"}, got_lat, elat);
    check({tag, ".z"}, got_z, ez);
    check({tag, ".ovrf"}, got_ov, eov);
    check({tag, ".udrf"}, got_ud, eud);
    check({tag, ".in_ready_busy"}, got_rdy, 1'b0);
    release_out(tag);
  endtask

  initial begin
    bit seen;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    fp_X = '0; fp_Y = '0; r_mode = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.in_ready", in_ready, 1'b1);
    check("rst.out_valid", out_valid, 1'b0);
    check("rst.fp_Z", fp_Z, 32'h0);
    check("rst.flags", {ovrf, udrf}, 2'b00);
    check("rst.dbg_prod", dbg_prod, 48'h0);
    @(negedge clk);
    rst = 1'b0;

    // Basic product and latency
    run("t1", 32'h3FC00000, 32'h40000000, 3'd0, 32'h40400000, 1'b0, 1'b0, 15);
    check("t1.prod", got_prod, 48'h6000_0000_0000);

    // Sticky-only rounding
    run("t2_rne", 32'h3F800001, 32'h3F800001, 3'd0, 32'h3F800002, 1'b0, 1'b0, 15);
    check("t2.prod", got_prod, 48'h4000_0100_0001);
    run("t2_rtz", 32'h3F800001, 32'h3F800001, 3'd1, 32'h3F800002, 1'b0, 1'b0, 15);
    run("t2_rup", 32'h3F800001, 32'h3F800001, 3'd3, 32'h3F800003, 1'b0, 1'b0, 15);
    run("t2_rdn", 32'h3F800001, 32'h3F800001, 3'd2, 32'h3F800002, 1'b0, 1'b0, 15);
    run("t2_rmm", 32'h3F800001, 32'h3F800001, 3'd4, 32'h3F800002, 1'b0, 1'b0, 15);
    run("t2n_rdn", 32'hBF800001, 32'h3F800001, 3'd2, 32'hBF800003, 1'b0, 1'b0, 15);
    run("t2n_rup", 32'hBF800001, 32'h3F800001, 3'd3, 32'hBF800002, 1'b0, 1'b0, 15);

    // Mx*My = 2**47-1: all-ones significand, round carry renormalises
    run("carry_rne", 32'h3FCA6691, 32'h3FA1E58F, 3'd0, 32'h40000000, 1'b0, 1'b0, 15);
    check("carry.prod", got_prod, 48'h7FFF_FFFF_FFFF);
    run("carry_rtz", 32'h3FCA6691, 32'h3FA1E58F, 3'd1, 32'h3FFFFFFF, 1'b0, 1'b0, 15);
    run("carry_rm7", 32'h3FCA6691, 32'h3FA1E58F, 3'd7, 32'h40000000, 1'b0, 1'b0, 15);
    run("carry_ovf", 32'h5FCA6691, 32'h5F21E58F, 3'd0, 32'h7F800000, 1'b1, 1'b0, 15);
    run("carry_novf", 32'h5FCA6691, 32'h5F21E58F, 3'd1, 32'h7F7FFFFF, 1'b0, 1'b0, 15);

    // Special operands
    run("spc_sub", 32'h00000001, 32'hC0000000, 3'd0, 32'h80000000, 1'b0, 1'b0, 1);
    run("spc_infz", 32'h7F800000, 32'h00000000, 3'd0, 32'h7FC00000, 1'b0, 1'b0, 1);
    run("spc_ninf", 32'hFF800000, 32'h3F800000, 3'd0, 32'hFF800000, 1'b0, 1'b0, 1);
    run("spc_nan", 32'h7F800001, 32'h3F800000, 3'd3, 32'h7FC00000, 1'b0, 1'b0, 1);
    run("spc_zero", 32'h00000000, 32'h80000000, 3'd0, 32'h80000000, 1'b0, 1'b0, 1);

    // Overflow per rounding mode
    run("ovf_rne", 32'h7F000000, 32'h7F000000, 3'd0, 32'h7F800000, 1'b1, 1'b0, 15);
    run("ovf_rtz", 32'h7F000000, 32'h7F000000, 3'd1, 32'h7F7FFFFF, 1'b1, 1'b0, 15);
    run("ovf_rdn", 32'h7F000000, 32'h7F000000, 3'd2, 32'h7F7FFFFF, 1'b1, 1'b0, 15);
    run("ovf_rup", 32'h7F000000, 32'h7F000000, 3'd3, 32'h7F800000, 1'b1, 1'b0, 15);
    run("ovfn_rdn", 32'hFF000000, 32'h7F000000, 3'd2, 32'hFF800000, 1'b1, 1'b0, 15);
    run("ovfn_rup", 32'hFF000000, 32'h7F000000, 3'd3, 32'hFF7FFFFF, 1'b1, 1'b0, 15);
    run("ovfn_rmm", 32'hFF000000, 32'h7F000000, 3'd4, 32'hFF800000, 1'b1, 1'b0, 15);

    // Underflow
    run("udf_pos", 32'h00800000, 32'h3F000000, 3'd0, 32'h00000000, 1'b0, 1'b1, 15);
    run("udf_neg", 32'h80800000, 32'h3F000000, 3'd3, 32'h80000000, 1'b0, 1'b1, 15);

    // Output held while out_ready is low
    issue(32'h3FC00000, 32'h40000000, 3'd0);
    check("hold.lat", got_lat, 15);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("hold.out_valid", out_valid, 1'b1);
      check("hold.fp_Z", fp_Z, 32'h40400000);
      check("hold.flags", {ovrf, udrf}, 2'b00);
      check("hold.in_ready", in_ready, 1'b0);
    end
    release_out("hold");

    // Reset during the 5th MUL cycle aborts the operation
    @(negedge clk);
    fp_X = 32'h3F800001; fp_Y = 32'h3F800001; r_mode = 3'd0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort.out_valid_now", out_valid, 1'b0);
    check("abort.in_ready_now", in_ready, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("abort.out_valid", out_valid, 1'b0);
    check("abort.in_ready", in_ready, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("abort.no_result", seen, 1'b0);
    run("after_abort", 32'h3FC00000, 32'h40000000, 3'd0, 32'h40400000, 1'b0, 1'b0, 15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
